alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_pkg.sv | 92 +++++++++
 rtl/alu_iter_muldiv.sv | 189 ++++++++++++++++++
 rtl/alu_exec_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared constants, operation and FSM enums for alu_exec_unit.
// Divide support (funct 011010/011011) exists only when ALU_EXEC_DIV_EN is defined.
package alu_exec_pkg;

    // Main-decoder operation classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
`ifdef ALU_EXEC_DIV_EN
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
`endif

    // Internal operation after decode
    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NOR,
        OP_SLT,
        OP_SLTU,
        OP_MFHI,
        OP_MFLO,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU
    } op_e;

    // Iterative unit states
    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_e;

    // Map alu_op/funct to an internal operation; anything unlisted is an add.
    function automatic op_e decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
        op_e op;
        op = OP_ADD;
        case (alu_op)
            ALUOP_ADD, ALUOP_RSVD: op = OP_ADD;
            ALUOP_SUB:             op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:   op = OP_ADD;
                    FUNCT_SUB:   op = OP_SUB;
                    FUNCT_AND:   op = OP_AND;
                    FUNCT_OR:    op = OP_OR;
                    FUNCT_SLT:   op = OP_SLT;
                    FUNCT_SLTU:  op = OP_SLTU;
                    FUNCT_XOR:   op = OP_XOR;
                    FUNCT_NOR:   op = OP_NOR;
                    FUNCT_MULT:  op = OP_MULT;
                    FUNCT_MULTU: op = OP_MULTU;
                    FUNCT_MFHI:  op = OP_MFHI;
                    FUNCT_MFLO:  op = OP_MFLO;
`ifdef ALU_EXEC_DIV_EN
                    FUNCT_DIV:   op = OP_DIV;
                    FUNCT_DIVU:  op = OP_DIVU;
`endif
                    default:     op = OP_ADD;
                endcase
            end
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    // True for operations handled by the multi-cycle multiply/divide unit.
    function automatic logic is_iter_op(input op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: iterative 1-bit-per-cycle multiplier (and restoring divider
// when ALU_EXEC_DIV_EN is defined), its iteration counter and the HI/LO pair.
// Signed operations run on magnitudes and fix the sign on the final cycle.
module alu_iter_muldiv
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
`ifdef ALU_EXEC_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   acc_q, acc_d;       // product high half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;         // multiplier / dividend-quotient shifter
    logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;       // final product/quotient must be negated
`ifdef ALU_EXEC_DIV_EN
    logic             div_q, div_d;
    logic             rneg_q, rneg_d;     // remainder takes the dividend's sign
    logic             dz_q, dz_d;         // divisor was zero
    logic [WIDTH-1:0] dvd_q, dvd_d;       // original dividend, returned in HI on /0
    logic [WIDTH:0]   rem_sh, rem_diff;
`endif

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, mul_pick;
    logic [2*WIDTH:0]   mul_shift;
    logic [WIDTH:0]     acc_step;
    logic [WIDTH-1:0]   mq_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // One iteration of shift-add (or restoring subtract) and the final sign fix-up.
    always_comb begin
        mul_sum   = acc_q + {1'b0, mcand_q};
        mul_pick  = mq_q[0] ? mul_sum : acc_q;
        mul_shift = {mul_pick, mq_q} >> 1;
        acc_step  = mul_shift[2*WIDTH:WIDTH];
        mq_step   = mul_shift[WIDTH-1:0];
`ifdef ALU_EXEC_DIV_EN
        rem_sh   = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, mcand_q};
        if (div_q) begin
            if (!rem_diff[WIDTH]) begin
                acc_step = rem_diff;
                mq_step  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = rem_sh;
                mq_step  = {mq_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
        prod = {acc_step[WIDTH-1:0], mq_step};
        if (neg_q) begin
            prod = ~prod + 1'b1;
        end
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
`ifdef ALU_EXEC_DIV_EN
        if (div_q) begin
            fin_lo = neg_q  ? (~mq_step + 1'b1) : mq_step;
            fin_hi = rneg_q ? (~acc_step[WIDTH-1:0] + 1'b1) : acc_step[WIDTH-1:0];
            if (dz_q) begin
                fin_lo = '1;
                fin_hi = dvd_q;
            end
        end
`endif
    end

    // FSM next state: load on start, iterate WIDTH times, commit HI/LO, hold until ack.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef ALU_EXEC_DIV_EN
        div_d   = div_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        dvd_d   = dvd_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ITER;
                    count_d = '0;
                    acc_d   = '0;
                    mq_d    = b_mag;
                    mcand_d = a_mag;
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_EXEC_DIV_EN
                    div_d   = is_div;
                    rneg_d  = is_signed & a[WIDTH-1];
                    dz_d    = (b == '0);
                    dvd_d   = a;
                    if (is_div) begin
                        mq_d    = a_mag;
                        mcand_d = b_mag;
                    end
`endif
                end
            end
            ITER: begin
                acc_d   = acc_step;
                mq_d    = mq_step;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    count_d = '0;
                    hi_d    = fin_hi;
                    lo_d    = fin_lo;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation and clears HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef ALU_EXEC_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            dvd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef ALU_EXEC_DIV_EN
            div_q   <= div_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            dvd_q   <= dvd_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decode, single-cycle ALU and valid/ready handshake around the
// iterative multiply/divide unit. Define ALU_EXEC_DIV_EN to add div/divu.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH              = 32,
    parameter int MUL_SIGNED_DEFAULT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    generate
        if ((WIDTH < 8) || (WIDTH > 64) || ((WIDTH % 2) != 0) ||
            (MUL_SIGNED_DEFAULT < 0) || (MUL_SIGNED_DEFAULT > 1)) begin : g_param_check
            $error("alu_exec_unit: WIDTH must be even in 8..64 and MUL_SIGNED_DEFAULT 0 or 1");
        end
    endgenerate

    op_e              op;
    logic             iter_op;
    logic             accept;
    logic             md_signed;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] and_v, or_v, xor_v, nor_v;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;

    assign op        = decode_op(alu_op, funct);
    assign iter_op   = is_iter_op(op);
    assign md_signed = (op == OP_MULT) || (op == OP_DIV);
    assign in_ready  = !rst && !md_busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // Bitwise logic unit
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_v[gi] = a[gi] & b[gi];
            assign or_v[gi]  = a[gi] | b[gi];
            assign xor_v[gi] = a[gi] ^ b[gi];
            assign nor_v[gi] = ~(a[gi] | b[gi]);
        end
    endgenerate

    // Single-cycle result selection; add/sub wrap, compares are zero-extended.
    always_comb begin
        alu_res = a + b;
        case (op)
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = and_v;
            OP_OR:   alu_res = or_v;
            OP_XOR:  alu_res = xor_v;
            OP_NOR:  alu_res = nor_v;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI: alu_res = md_hi;
            OP_MFLO: alu_res = md_lo;
            default: alu_res = a + b;
        endcase
    end

    // Output register for single-cycle ops; held until the consumer takes it.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        if (accept && !iter_op) begin
            valid_d  = 1'b1;
            result_d = alu_res;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Single-cycle result/valid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && iter_op),
        .is_signed (md_signed),
`ifdef ALU_EXEC_DIV_EN
        .is_div    ((op == OP_DIV) || (op == OP_DIVU)),
`endif
        .a         (a),
        .b         (b),
        .ack       (out_ready),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    // The iterative unit only reaches DONE when no single-cycle result is pending.
    assign out_valid = valid_q | md_done;
    assign result    = md_done ? md_lo : result_q;
    assign zero      = (result == '0);
    assign busy      = md_busy;

endmodule
